// File: rtl/rgmii_mac_tx_pkg.sv
// Shared types and constants for the RGMII transmit MAC and its CRC engine.
package rgmii_mac_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    PAD,
    FCS,
    DROP,
    IFG
  } tx_state_t;

  localparam logic [7:0]  ETH_PRE       = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  // Register value left after running the CRC over a frame plus its own FCS.
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational byte-wide step of the reflected Ethernet CRC32 (LSB-first).
module eth_crc32_byte
  import rgmii_mac_tx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/rgmii_mac_tx.sv
// RGMII transmit MAC: preamble/SFD insertion, IFG enforcement and, when built
// with RGMII_TX_FCS_EN defined, zero padding and FCS generation.
module rgmii_mac_tx #(
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int IFG_BYTES        = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [3:0] rgmii_txd_1,
  output logic [3:0] rgmii_txd_2,
  output logic       rgmii_tx_ctl_1,
  output logic       rgmii_tx_ctl_2,
  output logic       start_packet,
  output logic       error_underflow
);
  import rgmii_mac_tx_pkg::*;

  localparam logic [15:0] PRE_LAST = 16'd7;
  localparam logic [15:0] IFG_LAST = 16'((IFG_BYTES > 1) ? IFG_BYTES - 1 : 0);

  tx_state_t   state, state_n;
  logic [15:0] cnt, cnt_n, cnt_inc;
  logic [15:0] aux, aux_n;
  logic [7:0]  txd_n;
  logic        en_n, er_n, sp_n, uf_n;

  assign cnt_inc       = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign s_axis_tready = (state == PAYLOAD) || (state == DROP);

`ifdef RGMII_TX_FCS_EN
  localparam logic [15:0] PAD_LEN =
    16'((MIN_FRAME_LENGTH > 4) ? MIN_FRAME_LENGTH - 4 : 0);

  logic [31:0] crc, crc_n, crc_next, fcs;
  logic [7:0]  crc_data;

  // Pad bytes feed zeros into the CRC; only payload bytes come from the stream.
  assign crc_data = (state == PAYLOAD) ? s_axis_tdata : 8'h00;
  assign fcs      = ~crc;

  eth_crc32_byte u_crc (
    .crc_in  (crc),
    .data    (crc_data),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) crc <= 32'hFFFFFFFF;
    else     crc <= crc_n;
  end
`else
  logic unused_min_frame_length;
  assign unused_min_frame_length = (MIN_FRAME_LENGTH > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 16'd0;
      aux             <= 16'd0;
      rgmii_txd_1     <= 4'h0;
      rgmii_txd_2     <= 4'h0;
      rgmii_tx_ctl_1  <= 1'b0;
      rgmii_tx_ctl_2  <= 1'b0;
      start_packet    <= 1'b0;
      error_underflow <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      aux             <= aux_n;
      rgmii_txd_1     <= txd_n[3:0];
      rgmii_txd_2     <= txd_n[7:4];
      rgmii_tx_ctl_1  <= en_n;
      rgmii_tx_ctl_2  <= en_n ^ er_n;
      start_packet    <= sp_n;
      error_underflow <= uf_n;
    end
  end

  // aux counts preamble bytes, FCS byte index and IFG cycles depending on state.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    aux_n   = aux;
    txd_n   = 8'h00;
    en_n    = 1'b0;
    er_n    = 1'b0;
    sp_n    = 1'b0;
    uf_n    = 1'b0;
`ifdef RGMII_TX_FCS_EN
    crc_n   = crc;
`endif
    case (state)
      IDLE: begin
        if (s_axis_tvalid) begin
          txd_n   = ETH_PRE;
          en_n    = 1'b1;
          sp_n    = 1'b1;
          aux_n   = 16'd1;
          state_n = PREAMBLE;
        end
      end
      PREAMBLE: begin
        en_n = 1'b1;
        if (aux < PRE_LAST) begin
          txd_n = ETH_PRE;
          aux_n = aux + 16'd1;
        end else begin
          txd_n   = ETH_SFD;
          cnt_n   = 16'd0;
`ifdef RGMII_TX_FCS_EN
          crc_n   = 32'hFFFFFFFF;
`endif
          state_n = PAYLOAD;
        end
      end
      PAYLOAD: begin
        en_n = 1'b1;
        if (s_axis_tvalid) begin
          txd_n = s_axis_tdata;
          cnt_n = cnt_inc;
`ifdef RGMII_TX_FCS_EN
          crc_n = crc_next;
`endif
          if (s_axis_tlast) begin
            aux_n = 16'd0;
            if (s_axis_tuser) begin
              er_n    = 1'b1;
              state_n = IFG;
            end else begin
`ifdef RGMII_TX_FCS_EN
              state_n = (cnt_inc < PAD_LEN) ? PAD : FCS;
`else
              state_n = IFG;
`endif
            end
          end
        end else begin
          // Source starved mid-frame: poison the symbol and flush the rest.
          er_n    = 1'b1;
          uf_n    = 1'b1;
          state_n = DROP;
        end
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          aux_n   = 16'd0;
          state_n = IFG;
        end
      end
`ifdef RGMII_TX_FCS_EN
      PAD: begin
        en_n  = 1'b1;
        cnt_n = cnt_inc;
        crc_n = crc_next;
        if (cnt_inc >= PAD_LEN) begin
          aux_n   = 16'd0;
          state_n = FCS;
        end
      end
      FCS: begin
        en_n  = 1'b1;
        aux_n = aux + 16'd1;
        case (aux[1:0])
          2'd0:    txd_n = fcs[7:0];
          2'd1:    txd_n = fcs[15:8];
          2'd2:    txd_n = fcs[23:16];
          default: txd_n = fcs[31:24];
        endcase
        if (aux[1:0] == 2'd3) begin
          aux_n   = 16'd0;
          state_n = IFG;
        end
      end
`endif
      IFG: begin
        if (aux >= IFG_LAST) state_n = IDLE;
        else                 aux_n   = aux + 16'd1;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rgmii_mac_tx.sv
// Self-checking bench for rgmii_mac_tx against a frame-level reference model;
// follows RGMII_TX_FCS_EN the same way the design does.
`timescale 1ns/1ps
module tb_rgmii_mac_tx;

  localparam int IFG = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tdata = 8'h00;
  logic       tvalid = 1'b0;
  logic       tlast = 1'b0;
  logic       tuser = 1'b0;
  logic       sel = 1'b1;

  logic       ready_a, c1_a, c2_a, sp_a, uf_a;
  logic [3:0] txd1_a, txd2_a;
  logic       ready_b, c1_b, c2_b, sp_b, uf_b;
  logic [3:0] txd1_b, txd2_b;
  logic       ready, c1, c2, sp, uf;
  logic [3:0] txd1, txd2;

  rgmii_mac_tx dut_a (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(ready_a), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .rgmii_txd_1(txd1_a), .rgmii_txd_2(txd2_a), .rgmii_tx_ctl_1(c1_a),
    .rgmii_tx_ctl_2(c2_a), .start_packet(sp_a), .error_underflow(uf_a)
  );

  rgmii_mac_tx #(.MIN_FRAME_LENGTH(13), .IFG_BYTES(12)) dut_b (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(ready_b), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .rgmii_txd_1(txd1_b), .rgmii_txd_2(txd2_b), .rgmii_tx_ctl_1(c1_b),
    .rgmii_tx_ctl_2(c2_b), .start_packet(sp_b), .error_underflow(uf_b)
  );

  // sel=1 observes the MIN_FRAME_LENGTH=13 instance, sel=0 the default one.
  assign ready = sel ? ready_b : ready_a;
  assign c1    = sel ? c1_b    : c1_a;
  assign c2    = sel ? c2_b    : c2_a;
  assign sp    = sel ? sp_b    : sp_a;
  assign uf    = sel ? uf_b    : uf_a;
  assign txd1  = sel ? txd1_b  : txd1_a;
  assign txd2  = sel ? txd2_b  : txd2_a;

  always #4 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, frame_no = 0;
  int sp_cnt = 0, run_cnt = 0, uf_cnt = 0, exp_uf = 0;
  int idle_bad = 0, sp_bad = 0, gap_bad = 0;
  int last_end = -1, last_gap = -1;
  bit in_run = 0, run_rst = 0, prev_c1 = 0;
  logic [8:0] cur[$];
  logic [8:0] cap[$];
  logic [8:0] exp_sym[$];
  int         exp_len[$];
  logic [7:0] frm[$];

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] crcUpd(logic [31:0] c, logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Expected symbol stream of one frame as {TX_EN^TX_ER, byte} per TX_EN cycle.
  task automatic buildExpected(input bit abort, input int uf_at);
    logic [8:0]  r[$];
    logic [31:0] c;
    int          len = frm.size();
    int          min_len = sel ? 13 : 64;
    repeat (7) r.push_back({1'b1, 8'h55});
    r.push_back({1'b1, 8'hD5});
    if (uf_at > 0) begin
      for (int i = 0; i < uf_at; i++) r.push_back({1'b1, frm[i]});
      r.push_back({1'b0, 8'h00});
    end else if (abort) begin
      for (int i = 0; i < len; i++) r.push_back({(i != len - 1), frm[i]});
    end else begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < len; i++) begin
        r.push_back({1'b1, frm[i]});
        c = crcUpd(c, frm[i]);
      end
`ifdef RGMII_TX_FCS_EN
      for (int i = len; i < min_len - 4; i++) begin
        r.push_back({1'b1, 8'h00});
        c = crcUpd(c, 8'h00);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) r.push_back({1'b1, c[8*k +: 8]});
`else
      if (min_len < 0) r.push_back(9'h000);
`endif
    end
    exp_len.push_back(r.size());
    foreach (r[i]) exp_sym.push_back(r[i]);
  endtask

  task automatic finishRun();
    logic [8:0] e[$];
    int n, m, idx;
    frame_no++;
    cap = cur;
    if (exp_len.size() == 0) begin
      checkOutput($sformatf("frame%0d_unexpected", frame_no), cur.size(), 0);
      return;
    end
    n = exp_len.pop_front();
    for (int i = 0; i < n; i++) e.push_back(exp_sym.pop_front());
    checkOutput($sformatf("frame%0d_len", frame_no), cur.size(), n);
    m = (cur.size() < n) ? cur.size() : n;
    idx = m - 1;
    for (int i = m - 1; i >= 0; i--) if (cur[i] !== e[i]) idx = i;
    checkOutput($sformatf("frame%0d_sym%0d", frame_no, idx), cur[idx], e[idx]);
  endtask

  // Splits the pin stream into TX_EN runs and checks idle, gap and pulse rules.
  always @(negedge clk) begin
    cyc++;
    if (rst) last_end = -1;
    if (rst && in_run) run_rst = 1;
    if (sp === 1'b1) sp_cnt++;
    if (uf === 1'b1) uf_cnt++;
    if (sp === 1'b1 && !(c1 === 1'b1 && !prev_c1)) sp_bad++;
    if (c1 === 1'b1) begin
      if (!in_run) begin
        in_run = 1;
        run_rst = rst;
        run_cnt++;
        cur.delete();
        if (last_end >= 0) begin
          last_gap = cyc - last_end - 1;
          if (last_gap < IFG) gap_bad++;
        end else last_gap = -1;
      end
      cur.push_back({c2, txd2, txd1});
    end else begin
      if (!rst && ({txd2, txd1, c2} !== 9'h000)) idle_bad++;
      if (in_run) begin
        in_run = 0;
        if (run_rst || rst) last_end = -1;
        else begin
          last_end = cyc - 1;
          finishRun();
        end
      end
    end
    prev_c1 = (c1 === 1'b1);
  end

  task automatic waitAccept();
    bit acc = 0;
    int n = 0;
    while (!acc && n < 4000) begin
      @(negedge clk);
      acc = (ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input bit abort, input int uf_at, input int uf_hold, input int gap);
    int len = frm.size();
    buildExpected(abort, uf_at);
    if (uf_at > 0) exp_uf++;
    for (int i = 0; i < len; i++) begin
      if (uf_at > 0 && i == uf_at) begin
        tvalid = 0;
        tlast = 0;
        repeat (uf_hold) @(posedge clk);
        #1;
      end
      tdata  = frm[i];
      tlast  = (i == len - 1);
      tuser  = abort && (i == len - 1);
      tvalid = 1;
      waitAccept();
    end
    if (gap > 0) begin
      tvalid = 0; tlast = 0; tuser = 0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    tvalid = 0; tlast = 0; tuser = 0;
    while ((exp_len.size() != 0 || in_run) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) checkOutput("drain_timeout", exp_len.size(), 0);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic randFrame(input int len);
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(8'($urandom()));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] c;
    int len, mode, ufk;

    rst = 1; tvalid = 1; tdata = 8'h11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_outputs", {txd2, txd1, c1, c2, sp, uf}, 0);
    checkOutput("rst_tready", ready, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    checkOutput("rst_no_early_start", sp, 0);
    @(negedge clk);
    checkOutput("rst_first_start", {sp, c1, txd2, txd1}, {1'b1, 1'b1, 8'h55});
    @(posedge clk); #1 rst = 1; tvalid = 0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_midframe_idle", {txd2, txd1, c1, c2, ready}, 0);
    @(posedge clk); #1 rst = 0;
    repeat (3) @(posedge clk);
    #1;

    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    applyStimulus(0, 0, 0, 0);
    waitDrain();
`ifdef RGMII_TX_FCS_EN
    checkOutput("ascii_txen_cycles", cap.size(), 21);
    checkOutput("ascii_fcs", {cap[20][7:0], cap[19][7:0], cap[18][7:0], cap[17][7:0]}, 32'hCBF43926);
`else
    checkOutput("ascii_txen_cycles", cap.size(), 17);
`endif

    rst = 1;
    repeat (2) @(posedge clk);
    #1 sel = 0;
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    #1;

    frm = '{8'hAB};
    applyStimulus(0, 0, 0, 0);
    waitDrain();
`ifdef RGMII_TX_FCS_EN
    checkOutput("pad_txen_cycles", cap.size(), 72);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < cap.size(); i++) c = crcUpd(c, cap[i][7:0]);
    checkOutput("pad_residue", c, rgmii_mac_tx_pkg::CRC32_RESIDUE);
`else
    checkOutput("pad_txen_cycles", cap.size(), 9);
`endif

    begin
      int uf0 = uf_cnt;
      randFrame(100);
      applyStimulus(0, 5, 3, 0);
      waitDrain();
      checkOutput("uf_pulses", uf_cnt - uf0, 1);
      checkOutput("uf_txen_cycles", cap.size(), 14);
    end

    randFrame(64);
    applyStimulus(0, 0, 0, 0);
    randFrame(64);
    applyStimulus(1, 0, 0, 0);
    waitDrain();
    checkOutput("b2b_gap", last_gap, IFG);
    checkOutput("abort_txen_cycles", cap.size(), 72);
    checkOutput("abort_last_ctl2", cap[cap.size() - 1][8], 0);

    frm = '{8'h01, 8'h02, 8'h03};
    applyStimulus(0, 0, 0, 0);
    waitDrain();
`ifdef RGMII_TX_FCS_EN
    checkOutput("three_byte_txen_cycles", cap.size(), 72);
`else
    checkOutput("three_byte_txen_cycles", cap.size(), 11);
`endif

    for (int f = 0; f < 12; f++) begin
      len  = $urandom_range(1, 90);
      mode = $urandom_range(0, 5);
      ufk  = (mode == 1 && len >= 2) ? $urandom_range(1, len - 1) : 0;
      randFrame(len);
      applyStimulus(mode == 0, ufk, $urandom_range(1, 4), $urandom_range(0, 3));
    end
    waitDrain();

    checkOutput("start_pulses_vs_frames", sp_cnt, run_cnt);
    checkOutput("start_pulse_misplaced", sp_bad, 0);
    checkOutput("idle_not_zero", idle_bad, 0);
    checkOutput("ifg_too_short", gap_bad, 0);
    checkOutput("underflow_pulses", uf_cnt, exp_uf);
    checkOutput("leftover_expected", exp_len.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgmii_mac_tx.md
# rgmii_mac_tx

MAC-side RGMII transmitter that drives the PHY's TXD/TX_CTL pins at gigabit rate. It accepts frame bytes on an AXI-stream style input and performs the following framing:
- inserts preamble and SFD;
- pads short frames;
- appends the Ethernet FCS;
- enforces the inter-frame gap.

It emits the rising- and falling-edge halves of each RGMII symbol per clock, for an external DDR output register. It is the transmit counterpart that feeds a PHY model's TX pins in the RGMII PHY benches.

## Interface
Parameters:
- MIN_FRAME_LENGTH, 64: minimum frame length in bytes, including FCS. Payload is zero-padded up to MIN_FRAME_LENGTH-4 bytes. A value ≤ 4 disables padding.
- IFG_BYTES, 12: idle cycles enforced after the last byte of each frame (minimum 1).

Ports:
- clk  in  1  byte clock (125 MHz); all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  8  frame byte.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  byte accepted when tvalid & tready.
- s_axis_tlast  in  1  last byte of frame.
- s_axis_tuser  in  1  abort/error flag, sampled with tlast.
- rgmii_txd_1  out  4  nibble for the rising edge (byte bits [3:0]).
- rgmii_txd_2  out  4  nibble for the falling edge (byte bits [7:4]).
- rgmii_tx_ctl_1  out  1  TX_EN.
- rgmii_tx_ctl_2  out  1  TX_EN xor TX_ER.
- start_packet  out  1  one-cycle pulse when the first preamble byte is driven.
- error_underflow  out  1  one-cycle pulse on mid-frame tvalid drop.

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, PAD, FCS, DROP, IFG.
- IDLE: drive idle output. If tvalid=1, load 0x55, set TX_EN, go to PREAMBLE with byte count 1, and pulse start_packet.
- PREAMBLE: drive six more 0x55 bytes, then 0xD5 (SFD), then go to PAYLOAD.
- PAYLOAD:
  - tready = 1, combinational from state only.
  - Each accepted byte is loaded into the output register and into the CRC, and the frame counter increments.
  - On tlast with tuser=0:
    - if the counter is below MIN_FRAME_LENGTH-4, go to PAD;
    - otherwise go to FCS.
  - On tlast with tuser=1: drive that byte with TX_ER=1 and go to IFG (no FCS).
- Underflow: tvalid=0 in PAYLOAD (tlast not yet seen) →
  - drive 0x00 with TX_EN=1 and TX_ER=1;
  - pulse error_underflow;
  - go to DROP.
- DROP: tready=1. Discard input up to and including tlast while driving idle, then go to IFG.
- PAD: drive 0x00 bytes, with CRC updated, until the count reaches MIN_FRAME_LENGTH-4, then go to FCS.
- FCS: drive ~CRC least-significant byte first over 4 cycles, then go to IFG.
- IFG: drive idle for IFG_BYTES cycles, then go to IDLE.
- CRC32:
  - reflected polynomial 0xEDB88320;
  - preset to 0xFFFFFFFF on the SFD cycle;
  - covers payload and pad only.
- Frame counter: 16 bits, saturating, so no wrap for jumbo frames.
- Idle output: txd_1 = txd_2 = 0, tx_ctl_1 = tx_ctl_2 = 0.

## Timing
- All outputs are registered.
- Reset values: txd_1 = 0, txd_2 = 0, tx_ctl_1 = 0, tx_ctl_2 = 0, start_packet = 0, error_underflow = 0, s_axis_tready = 0, state = IDLE.
- If tvalid rises in cycle N (in IDLE): preamble appears from cycle N+1, SFD at N+8, tready=1 from cycle N+8, and the first payload byte is driven at N+9.
- The FCS's first byte is driven in the cycle after the last payload or pad byte.
- Back-to-back frames: the next start_packet occurs no earlier than IFG_BYTES+1 cycles after the last FCS byte.
- tvalid asserted during IFG is held off (tready=0); no bytes are lost.
- Reset mid-frame: outputs go idle on the next edge, state returns to IDLE, and no IFG is enforced. A partial frame on the input is not dropped; upstream must also reset.

## Configuration
- RGMII_TX_FCS_EN defined:
  - CRC engine, PAD and FCS states compiled in;
  - behaviour as above.
- RGMII_TX_FCS_EN undefined:
  - no CRC logic, no padding, no FCS;
  - the frame ends at tlast (PAYLOAD → IFG);
  - upstream supplies a complete frame, including FCS;
  - MIN_FRAME_LENGTH is ignored.

## Structure
- Shared package contains:
  - state enum;
  - ETH_PRE (0x55), ETH_SFD (0xD5) and CRC32_POLY (0xEDB88320) constants;
  - CRC32_RESIDUE (0xDEBB20E3) for benches.
- Sub-module eth_crc32_byte: combinational next-CRC from a 32-bit state and an 8-bit input. It is instantiated only under RGMII_TX_FCS_EN.

## Test plan
- Reset:
  - Stimulus: hold rst 3 cycles with tvalid=1.
  - Required response: all outputs 0, tready=0, no start_packet until 1 cycle after rst falls.
- Short frame with FCS:
  - Stimulus: MIN_FRAME_LENGTH=13, payload ASCII "123456789".
  - Required response, per cycle: 7×0x55, 0xD5, 9 payload bytes, FCS bytes 0x26 0x39 0xF4 0xCB; tx_ctl_1 = tx_ctl_2 = 1 for exactly 21 cycles; then 12 idle cycles.
- Padding:
  - Stimulus: default parameters, single-byte frame 0xAB.
  - Required response: 0xAB then 59×0x00 then 4 FCS bytes; 72 TX_EN cycles; CRC over frame+FCS equals residue 0xDEBB20E3.
- Underflow:
  - Stimulus: drop tvalid after payload byte 5 of 100; resume with remaining bytes.
  - Required response: one cycle with tx_ctl_1=1 and tx_ctl_2=0; error_underflow pulses once; remaining bytes accepted and discarded; no FCS; 12-cycle gap.
- Back-to-back frames and abort:
  - Stimulus: two 64-byte frames with tvalid held high, the second ending with tuser=1 on tlast.
  - Required response: exactly 12 idle cycles between frames; second frame's last byte has tx_ctl_2=0 and no FCS follows.
- Without RGMII_TX_FCS_EN:
  - Stimulus: 3-byte frame 0x01 0x02 0x03.
  - Required response: preamble, SFD, 0x01 0x02 0x03, then idle (11 TX_EN cycles).
